// File: rtl/parity_frame_checker.sv
// parity_frame_checker: deserialises an LSB-first DATA_W-bit word plus a trailing parity bit,
// checks parity and presents the word on a valid/ack output register.
// Optional feature macro: PARITY_ERRCNT_EN enables the saturating 8-bit parity-error counter.
module parity_frame_checker #(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              si,
   input  logic              sval,
   input  logic              sfrm,
   input  logic              dack,
   output logic [DATA_W-1:0] dout,
   output logic              dval,
   output logic              perr,
   output logic              abort,
   output logic              ovr,
   output logic [7:0]        errcnt
);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] sreg;
   logic              acc;
   logic [DATA_W:0]   ext;
   logic              done;
   logic              load;
   logic              bad;
   assign ext  = {si, sreg};
   assign done = sval & ~sfrm & (state == SHIFT) & (cnt == LAST);
   assign load = done & (~dval | dack);
   assign bad  = acc ^ si ^ ODD_PARITY;
   // frame FSM, shift register and registered valid/ack output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         sreg  <= '0;
         acc   <= 1'b0;
         dout  <= '0;
         dval  <= 1'b0;
         perr  <= 1'b0;
         abort <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         abort <= 1'b0;
         ovr   <= 1'b0;
         if (dval && dack) dval <= 1'b0;
         if (sval) begin
            if (sfrm) begin
               abort <= state == SHIFT;
               state <= SHIFT;
               cnt   <= CW'(1);
               acc   <= si;
               sreg  <= ext[DATA_W:1];
            end else if (state == SHIFT) begin
               if (cnt == LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (load) begin
                     dout <= sreg;
                     perr <= bad;
                     dval <= 1'b1;
                  end else begin
                     ovr <= 1'b1;
                  end
               end else begin
                  cnt  <= cnt + CW'(1);
                  acc  <= acc ^ si;
                  sreg <= ext[DATA_W:1];
               end
            end
         end
      end
   end
`ifdef PARITY_ERRCNT_EN
   // saturating count of loaded words that carried a parity error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) errcnt <= 8'h00;
      else if (load && bad && errcnt != 8'hFF) errcnt <= errcnt + 8'h01;
   end
`else
   assign errcnt = 8'h00;
`endif
endmodule
